wb_write_port_ctrl: RTL and testbench
=====================================

Name: wb_write_port_ctrl

Overview:
- Owns the single write port of the 32x32 integer register file and arbitrates the two writeback sources of the RV32IM pipeline:
  - the in-order MEM/WB stage, which has no backpressure;
  - the multicycle MUL/DIV unit, which uses a valid/ready handshake.
- MUL/DIV results that lose arbitration are buffered in a small FIFO.
- Drives the register file's WRITE/ADDRW/IN inputs and exports a pending-destination mask to the hazard unit.

Parameters:
- FIFO_DEPTH, 4, MUL/DIV result buffer entries; power of 2, minimum 2.
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset: synchronous, active-high.
- PIPE_VALID  in  1  MEM/WB has a register write this cycle.
- PIPE_RD  in  ADDR_W  MEM/WB destination register.
- PIPE_DATA  in  DATA_W  MEM/WB result.
- MD_VALID  in  1  MUL/DIV result offered.
- MD_RD  in  ADDR_W  MUL/DIV destination register.
- MD_DATA  in  DATA_W  MUL/DIV result.
- MD_READY  out  1  block accepts the MUL/DIV result this cycle.
- REG_WRITE  out  1  register file WRITE.
- REG_ADDRW  out  ADDR_W  register file ADDRW.
- REG_IN  out  DATA_W  register file IN.
- PEND_RD_MASK  out  32  bit r set when a live FIFO entry targets xr; bit 0 is always 0.
- FIFO_COUNT  out  clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- **Reset.** While RESET=1 at a posedge:
  - REG_WRITE=0, REG_ADDRW=0, REG_IN=0.
  - FIFO emptied: count=0, all entries dead, PEND_RD_MASK=0.
  - MD_READY is forced 0 combinationally while RESET=1.
  - REG_WRITE must stay 0 during reset so that the register file's own clear takes effect.
  - Reset mid-operation discards all buffered results; no write is issued for them.
- **Acceptance.**
  - MD_READY = !RESET && (count < FIFO_DEPTH).
  - An MD transfer occurs when MD_VALID && MD_READY.
  - PIPE writes are always accepted.
- **x0 filtering.**
  - PIPE_RD=0 is treated as no request.
  - An MD transfer with MD_RD=0 completes the handshake but is discarded: no push, no write.
- **Port selection each cycle, priority order:**
  1. PIPE_VALID && PIPE_RD!=0 → issue the PIPE write.
  2. Else, FIFO non-empty → pop the head. If the head is live, issue it; if dead, pop with no write.
  3. Else, an MD transfer is in progress with MD_RD!=0 and the FIFO is empty → bypass the MD write directly; no push.
  4. Else, REG_WRITE=0.
- **Push.** An MD transfer with MD_RD!=0 that is not bypassed is pushed at the tail.
- **Same-cycle push and pop.** count is unchanged and the head is popped before the new tail is read.
- **Latency.** REG_WRITE/REG_ADDRW/REG_IN are registered: a request sampled at edge N is presented after edge N and written by the register file at edge N+1. When REG_WRITE=0, REG_ADDRW and REG_IN hold their previous values.
- **Ordering.**
  - MD results are written in acceptance order.
  - PIPE is never stalled; the hazard unit uses PEND_RD_MASK to prevent RAW/WAW on queued destinations.
- **Pointers.** Read and write pointers wrap modulo FIFO_DEPTH. Full means count==FIFO_DEPTH and drops MD_READY in the same cycle, combinationally from the registered count.

Optional Feature:
- Macro: WB_WAW_SQUASH_EN.
- **Defined:** when a PIPE write to rd r issues, every live FIFO entry with rd==r is marked dead in the same edge.
  - Dead entries are later popped without a write.
  - Dead entries are cleared from PEND_RD_MASK immediately.
  - An MD bypass or push in the same cycle for the same r is not squashed.
- **Undefined:** there is no dead marking. Every accepted non-x0 MD result is eventually written, and WAW is solely the hazard unit's responsibility.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and ADDR_W constants;
  - typedef wb_entry_t {rd, data, live};
  - the source-select enum {SEL_NONE, SEL_PIPE, SEL_FIFO, SEL_BYPASS}.
- Sub-module wb_result_fifo contains:
  - the entry array, pointers and count;
  - live-bit squash (under the macro);
  - PEND_RD_MASK generation.
- The top level contains arbitration and the output registers.

Test Plan:
- **Reset clears state.** Hold RESET for 2 cycles while MD_VALID=1 → MD_READY=0, REG_WRITE=0, FIFO_COUNT=0, PEND_RD_MASK=0.
- **Bypass.** FIFO empty and PIPE idle; MD_VALID with rd=5, data=0x1234 → next cycle REG_WRITE=1, REG_ADDRW=5, REG_IN=0x1234; FIFO_COUNT stays 0.
- **Conflict, then drain.** PIPE rd=3/0xAAAA and MD rd=7/0xBBBB in the same cycle → write x3 first; FIFO_COUNT=1 and PEND_RD_MASK=0x80; the next cycle writes x7=0xBBBB and the mask returns to 0.
- **Full.** PIPE writes every cycle, 4 MD results rd=8..11 → FIFO_COUNT=4, MD_READY=0. Stop PIPE → x8..x11 are written in order over 4 cycles; MD_READY rises after the first pop.
- **x0 discard.** PIPE rd=0 plus MD rd=0 → REG_WRITE=0, handshake completes, FIFO_COUNT=0.
- **WAW squash (WB_WAW_SQUASH_EN defined).** FIFO holds rd=9 behind a PIPE stream; PIPE writes rd=9 → mask bit 9 clears and the entry pops with no write.
- **WAW, macro undefined.** Same stimulus → x9 is later overwritten with the MD value.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback port controller: register/data widths,
// the buffered MUL/DIV entry layout and the write-source select encoding.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              live;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_PIPE   = 2'd1,
    SEL_FIFO   = 2'd2,
    SEL_BYPASS = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Buffer for MUL/DIV results that lost write-port arbitration; also builds the
// pending-destination mask. WB_WAW_SQUASH_EN enables squashing of queued entries.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              squash_en,
  input  logic [ADDR_W-1:0] squash_rd,
  output wb_entry_t         head,
  output logic [CNT_W-1:0]  count,
  output logic [31:0]       pend_mask
);

  wb_entry_t        entries [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

`ifndef WB_WAW_SQUASH_EN
  logic unused_squash;
  assign unused_squash = ^{squash_en, squash_rd};
`endif

  // Squash runs before push so a same-cycle push to the same rd stays live.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) entries[i].live <= 1'b0;
    end else begin
`ifdef WB_WAW_SQUASH_EN
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (squash_en && entries[i].live && entries[i].rd == squash_rd)
          entries[i].live <= 1'b0;
      end
`endif
      if (pop) begin
        entries[rd_ptr].live <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        entries[wr_ptr] <= '{rd: push_rd, data: push_data, live: 1'b1};
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = entries[rd_ptr];

  // Popped slots are cleared above, so only occupied live entries contribute.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entries[i].live) pend_mask[entries[i].rd] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: rtl/wb_write_port_ctrl.sv
// Register-file write-port arbiter: MEM/WB has priority, then buffered MUL/DIV
// results, then a direct MUL/DIV bypass. Optional macro: WB_WAW_SQUASH_EN.
module wb_write_port_ctrl
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PIPE_VALID,
  input  logic [ADDR_W-1:0] PIPE_RD,
  input  logic [DATA_W-1:0] PIPE_DATA,
  input  logic              MD_VALID,
  input  logic [ADDR_W-1:0] MD_RD,
  input  logic [DATA_W-1:0] MD_DATA,
  output logic              MD_READY,
  output logic              REG_WRITE,
  output logic [ADDR_W-1:0] REG_ADDRW,
  output logic [DATA_W-1:0] REG_IN,
  output logic [31:0]       PEND_RD_MASK,
  output logic [CNT_W-1:0]  FIFO_COUNT
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // MUL/DIV handshake: a transfer occurs when MD_VALID && MD_READY on a posedge.
  // MD_READY depends only on RESET and the registered count, never on MD_VALID.
  wb_entry_t head;
  wb_sel_e   sel;
  logic      pipe_req;
  logic      md_xfer;
  logic      md_live;
  logic      fifo_empty;
  logic      push;
  logic      pop;

  assign MD_READY   = !RESET && (FIFO_COUNT < DEPTH_C);
  assign md_xfer    = MD_VALID && MD_READY;
  assign md_live    = md_xfer && (MD_RD != '0);
  assign pipe_req   = PIPE_VALID && (PIPE_RD != '0);
  assign fifo_empty = (FIFO_COUNT == '0);

  always_comb begin
    sel = SEL_NONE;
    if (pipe_req)         sel = SEL_PIPE;
    else if (!fifo_empty) sel = SEL_FIFO;
    else if (md_live)     sel = SEL_BYPASS;
  end

  assign pop  = (sel == SEL_FIFO);
  assign push = md_live && (sel != SEL_BYPASS);

  wb_result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK),
    .reset     (RESET),
    .push      (push),
    .push_rd   (MD_RD),
    .push_data (MD_DATA),
    .pop       (pop),
    .squash_en (pipe_req),
    .squash_rd (PIPE_RD),
    .head      (head),
    .count     (FIFO_COUNT),
    .pend_mask (PEND_RD_MASK)
  );

  // Address/data hold their last value whenever no write is issued.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      REG_WRITE <= 1'b0;
      REG_ADDRW <= '0;
      REG_IN    <= '0;
    end else begin
      REG_WRITE <= 1'b0;
      case (sel)
        SEL_PIPE: begin
          REG_WRITE <= 1'b1;
          REG_ADDRW <= PIPE_RD;
          REG_IN    <= PIPE_DATA;
        end
        SEL_FIFO: begin
          if (head.live) begin
            REG_WRITE <= 1'b1;
            REG_ADDRW <= head.rd;
            REG_IN    <= head.data;
          end
        end
        SEL_BYPASS: begin
          REG_WRITE <= 1'b1;
          REG_ADDRW <= MD_RD;
          REG_IN    <= MD_DATA;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_port_ctrl.sv
// Directed plus randomized bench for wb_write_port_ctrl against a queue-based
// reference model of the arbitration rules.
module tb_wb_write_port_ctrl;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PIPE_VALID;
  logic [4:0]  PIPE_RD;
  logic [31:0] PIPE_DATA;
  logic        MD_VALID;
  logic [4:0]  MD_RD;
  logic [31:0] MD_DATA;
  logic        MD_READY;
  logic        REG_WRITE;
  logic [4:0]  REG_ADDRW;
  logic [31:0] REG_IN;
  logic [31:0] PEND_RD_MASK;
  logic [2:0]  FIFO_COUNT;

  wb_write_port_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PIPE_VALID   (PIPE_VALID),
    .PIPE_RD      (PIPE_RD),
    .PIPE_DATA    (PIPE_DATA),
    .MD_VALID     (MD_VALID),
    .MD_RD        (MD_RD),
    .MD_DATA      (MD_DATA),
    .MD_READY     (MD_READY),
    .REG_WRITE    (REG_WRITE),
    .REG_ADDRW    (REG_ADDRW),
    .REG_IN       (REG_IN),
    .PEND_RD_MASK (PEND_RD_MASK),
    .FIFO_COUNT   (FIFO_COUNT)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // model FIFO contents, each entry {live, rd, data}
  logic [37:0] exp_q[$];
  logic        exp_write;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  bit          checks_on = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (exp_q[i]) if (exp_q[i][37]) m[exp_q[i][36:32]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_step(input logic rst, input logic pv, input logic [4:0] prd,
                            input logic [31:0] pd, input logic mv, input logic [4:0] mrd,
                            input logic [31:0] md);
    bit ready, preq, mlive;
    logic [37:0] h;
    if (rst) begin
      exp_q.delete();
      exp_write = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
      return;
    end
    ready = exp_q.size() < DEPTH;
    preq  = pv && (prd != 0);
    mlive = mv && ready && (mrd != 0);
`ifdef WB_WAW_SQUASH_EN
    if (preq) foreach (exp_q[i]) if (exp_q[i][36:32] == prd) exp_q[i][37] = 1'b0;
`endif
    exp_write = 1'b0;
    if (preq) begin
      exp_write = 1'b1; exp_addr = prd; exp_data = pd;
    end else if (exp_q.size() != 0) begin
      h = exp_q.pop_front();
      if (h[37]) begin
        exp_write = 1'b1; exp_addr = h[36:32]; exp_data = h[31:0];
      end
    end else if (mlive) begin
      exp_write = 1'b1; exp_addr = mrd; exp_data = md;
      mlive = 0;
    end
    if (mlive) exp_q.push_back({1'b1, mrd, md});
  endtask

  // driver: apply inputs at negedge, check state, advance model, cross posedge
  task automatic cyc(input logic rst, input logic pv, input logic [4:0] prd,
                     input logic [31:0] pd, input logic mv, input logic [4:0] mrd,
                     input logic [31:0] md);
    RESET = rst; PIPE_VALID = pv; PIPE_RD = prd; PIPE_DATA = pd;
    MD_VALID = mv; MD_RD = mrd; MD_DATA = md;
    #1;
    if (checks_on) begin
      chk("md_ready",  MD_READY,     (!rst && exp_q.size() < DEPTH));
      chk("reg_write", REG_WRITE,    exp_write);
      chk("reg_addrw", REG_ADDRW,    exp_addr);
      chk("reg_in",    REG_IN,       exp_data);
      chk("count",     FIFO_COUNT,   exp_q.size());
      chk("pend_mask", PEND_RD_MASK, model_mask());
    end
    model_step(rst, pv, prd, pd, mv, mrd, md);
    @(posedge CLK);
    @(negedge CLK);
    checks_on = 1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    // reset with MD_VALID asserted
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h77);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h77);
    chk("rst_write", REG_WRITE, 1'b0);
    chk("rst_count", FIFO_COUNT, 3'd0);
    chk("rst_mask", PEND_RD_MASK, 32'h0);
    idle();

    // bypass
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    chk("byp_write", REG_WRITE, 1'b1);
    chk("byp_addr", REG_ADDRW, 5'd5);
    chk("byp_data", REG_IN, 32'h1234);
    chk("byp_count", FIFO_COUNT, 3'd0);

    // conflict, then drain
    cyc(1'b0, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
    chk("cfl_addr", REG_ADDRW, 5'd3);
    chk("cfl_count", FIFO_COUNT, 3'd1);
    chk("cfl_mask", PEND_RD_MASK, 32'h80);
    idle();
    chk("drn_addr", REG_ADDRW, 5'd7);
    chk("drn_data", REG_IN, 32'hBBBB);
    chk("drn_mask", PEND_RD_MASK, 32'h0);

    // full
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 5'(1 + i), $urandom, 1'b1, 5'(8 + i), 32'hC000 + i);
    chk("full_count", FIFO_COUNT, 3'd4);
    chk("full_ready", MD_READY, 1'b0);
    idle();
    chk("full_addr0", REG_ADDRW, 5'd8);
    chk("full_ready_back", MD_READY, 1'b1);
    for (int i = 0; i < 3; i++) idle();
    chk("full_addr3", REG_ADDRW, 5'd11);
    idle();

    // x0 discard
    cyc(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    chk("x0_write", REG_WRITE, 1'b0);
    chk("x0_count", FIFO_COUNT, 3'd0);

    // WAW on rd 9
    cyc(1'b0, 1'b1, 5'd1, 32'h1111, 1'b1, 5'd9, 32'h9999);
    chk("waw_mask", PEND_RD_MASK, 32'h200);
    cyc(1'b0, 1'b1, 5'd9, 32'h5555, 1'b0, 5'd0, 32'd0);
    idle();
`ifdef WB_WAW_SQUASH_EN
    chk("waw_sq_write", REG_WRITE, 1'b0);
`else
    chk("waw_write", REG_WRITE, 1'b1);
    chk("waw_data", REG_IN, 32'h9999);
`endif
    idle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
          5'($urandom_range(0, 11)), $urandom, ($urandom_range(0, 1) == 1),
          5'($urandom_range(0, 11)), $urandom);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
